writeback_stage: RTL and testbench

- Final pipeline stage of the RV32I core: MEM/WB pipeline register, load-data extraction/extension, and the result mux.
- Sole driver of the register-file write port (ResultW, RdW, RegWriteW) that the Decode stage consumes.
- Arbitrates that write port between the main pipeline and an external multi-cycle unit (MUL/DIV) through a valid/ready handshake.
- Maintains the 64-bit retired-instruction counter.

---
 rtl/writeback_stage.sv | 156 +++++++++++++++
 tb/tb_writeback_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage of the RV32I core: MEM/WB register, load extraction, result
// mux, register-file write-port arbitration with an external unit, instret.
module writeback_stage #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned INSTRET_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ValidM,
  input  logic                 RegWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [2:0]           LoadTypeM,
  input  logic [4:0]           RdM,
  input  logic [31:0]          ALUResultM,
  input  logic [31:0]          ReadDataM,
  input  logic [31:0]          PCPlus4M,
  input  logic                 StallW,
  input  logic                 FlushW,
  input  logic                 ExtValid,
  input  logic [4:0]           ExtRd,
  input  logic [31:0]          ExtData,
  output logic                 ExtReady,
  output logic                 StallReqW,
  output logic [31:0]          ResultW,
  output logic [4:0]           RdW,
  output logic                 RegWriteW,
  output logic [INSTRET_W-1:0] InstretW
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned WAIT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic [1:0]       result_src;
    logic [2:0]       load_type;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  rdata;
    logic [XLEN-1:0]  pc4;
    logic [1:0]       offset;
  } mwb_t;

  mwb_t                 mwb_q, mwb_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [INSTRET_W-1:0] instret_q;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [XLEN-1:0]      load_data, pipe_data, wr_data;
  logic [REG_W-1:0]     wr_rd;
  logic                 wr_en, pipe_wr, starve, ext_ready_c;

  // MEM/WB capture: flush beats hold beats load; a starved external unit holds the entry
  always_comb begin
    mwb_d = mwb_q;
    if (FlushW) begin
      mwb_d = '0;
    end else if (!(StallW || starve)) begin
      mwb_d.valid      = ValidM;
      mwb_d.regwrite   = RegWriteM;
      mwb_d.result_src = ResultSrcM;
      mwb_d.load_type  = LoadTypeM;
      mwb_d.rd         = RdM;
      mwb_d.alu        = ALUResultM;
      mwb_d.rdata      = ReadDataM;
      mwb_d.pc4        = PCPlus4M;
      mwb_d.offset     = ALUResultM[1:0];
    end
  end

  // Load extraction and result mux
  always_comb begin
    ld_byte   = mwb_q.rdata[7:0];
    ld_half   = mwb_q.offset[1] ? mwb_q.rdata[31:16] : mwb_q.rdata[15:0];
    load_data = mwb_q.rdata;
    pipe_data = mwb_q.alu;
    case (mwb_q.offset)
      2'd1:    ld_byte = mwb_q.rdata[15:8];
      2'd2:    ld_byte = mwb_q.rdata[23:16];
      2'd3:    ld_byte = mwb_q.rdata[31:24];
      default: ld_byte = mwb_q.rdata[7:0];
    endcase
    case (mwb_q.load_type)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = mwb_q.rdata;
    endcase
    case (mwb_q.result_src)
      2'b01:   pipe_data = load_data;
      2'b10:   pipe_data = mwb_q.pc4;
      default: pipe_data = mwb_q.alu;
    endcase
  end

  // Write-port arbitration; everything forced quiet while reset is asserted
  always_comb begin
    pipe_wr     = mwb_q.valid && mwb_q.regwrite && (mwb_q.rd != '0);
    starve      = rst && ExtValid && (wait_q == WAIT_W'(STARVE_LIMIT)) && pipe_wr;
    ext_ready_c = 1'b0;
    wr_data     = pipe_data;
    wr_rd       = mwb_q.rd;
    wr_en       = 1'b0;
    if (!rst) begin
      wr_data = '0;
      wr_rd   = '0;
    end else if (starve) begin
      ext_ready_c = 1'b1;
      wr_data     = ExtData;
      wr_rd       = ExtRd;
      wr_en       = (ExtRd != '0);
    end else if (pipe_wr) begin
      ext_ready_c = ExtValid && (ExtRd == '0);
      wr_en       = 1'b1;
    end else begin
      ext_ready_c = ExtValid;
      if (ExtValid && (ExtRd != '0)) begin
        wr_data = ExtData;
        wr_rd   = ExtRd;
        wr_en   = 1'b1;
      end
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (!ExtValid || ext_ready_c) begin
      wait_d = '0;
    end else if (wait_q != WAIT_W'(STARVE_LIMIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mwb_q     <= '0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      mwb_q  <= mwb_d;
      wait_q <= wait_d;
      if (mwb_q.valid && !StallW && !starve) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  assign ExtReady  = ext_ready_c;
  assign StallReqW = starve;
  assign ResultW   = wr_data;
  assign RdW       = wr_rd;
  assign RegWriteW = wr_en;
  assign InstretW  = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: load/result table, directed handshake, starvation,
// stall/flush and reset sequences, then random traffic against a reference model.
module tb_writeback_stage;
  logic        clk, rst;
  logic        ValidM, RegWriteM, StallW, FlushW, ExtValid;
  logic [1:0]  ResultSrcM;
  logic [2:0]  LoadTypeM;
  logic [4:0]  RdM, ExtRd;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ExtData;
  logic        ExtReady, StallReqW, RegWriteW;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic [63:0] InstretW;

  writeback_stage #(.STARVE_LIMIT(4), .INSTRET_W(64)) dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .LoadTypeM(LoadTypeM), .RdM(RdM), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
    .PCPlus4M(PCPlus4M), .StallW(StallW), .FlushW(FlushW), .ExtValid(ExtValid),
    .ExtRd(ExtRd), .ExtData(ExtData), .ExtReady(ExtReady), .StallReqW(StallReqW),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .InstretW(InstretW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the W slot holds the already-computed write value
  logic        m_v, m_we, m_known, m_rdy;
  logic [4:0]  m_rd;
  logic [31:0] m_val;
  logic [63:0] m_ret;
  int          m_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_value(input logic [1:0] src, input logic [2:0] lt,
                                            input logic [31:0] alu, input logic [31:0] rdw,
                                            input logic [31:0] pc4);
    int unsigned off;
    longint      v;
    off = 32'(alu[1:0]);
    if (src == 2'b10) return pc4;
    if (src != 2'b01) return alu;
    case (lt)
      3'b000, 3'b100: begin
        v = longint'((rdw >> (8 * off)) & 32'hFF);
        if (lt == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = longint'((rdw >> (16 * (off / 2))) & 32'hFFFF);
        if (lt == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rdw);
    endcase
    return 32'(v);
  endfunction

  task automatic model_reset();
    m_v = 1'b0; m_we = 1'b0; m_known = 1'b1; m_rd = 5'd0; m_val = 32'd0;
    m_ret = 64'd0; m_wait = 0; m_rdy = 1'b0;
  endtask

  // Settle, compare every output with the model, then advance the model one clock
  task automatic step();
    logic pw, starve, rdy, we;
    logic [31:0] res;
    logic [4:0]  rd;
    #1;
    pw     = m_v && m_we && (m_rd != 5'd0);
    starve = ExtValid && (m_wait == 4) && pw;
    res = m_val; rd = m_rd; we = 1'b0; rdy = ExtValid;
    if (starve) begin
      rdy = 1'b1; res = ExtData; rd = ExtRd; we = (ExtRd != 5'd0);
    end else if (pw) begin
      we = 1'b1; rdy = ExtValid && (ExtRd == 5'd0);
    end else if (ExtValid && ExtRd != 5'd0) begin
      res = ExtData; rd = ExtRd; we = 1'b1;
    end
    chk("RegWriteW", 64'(RegWriteW), 64'(we));
    chk("ExtReady", 64'(ExtReady), 64'(rdy));
    chk("StallReqW", 64'(StallReqW), 64'(starve));
    chk("InstretW", InstretW, m_ret);
    if (we || m_known) begin
      chk("ResultW", 64'(ResultW), 64'(res));
      chk("RdW", 64'(RdW), 64'(rd));
    end
    m_rdy = rdy;
    if (ExtValid && !rdy) m_wait = (m_wait < 4) ? m_wait + 1 : 4;
    else m_wait = 0;
    if (m_v && !StallW && !starve) m_ret = m_ret + 64'd1;
    if (FlushW) begin
      m_v = 1'b0; m_we = 1'b0; m_known = 1'b0;
    end else if (!(StallW || starve)) begin
      m_v = ValidM; m_we = RegWriteM; m_rd = RdM; m_known = 1'b1;
      m_val = ref_value(ResultSrcM, LoadTypeM, ALUResultM, ReadDataM, PCPlus4M);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] lt, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] rdw, input logic [31:0] pc4);
    ValidM = v; RegWriteM = rw; ResultSrcM = src; LoadTypeM = lt; RdM = rd;
    ALUResultM = alu; ReadDataM = rdw; PCPlus4M = pc4;
  endtask

  task automatic ext_idle();
    ExtValid = 1'b0; ExtRd = 5'd1; ExtData = 32'd0;
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  src;
    logic [2:0]  lt;
    logic [4:0]  rd;
    logic [31:0] alu, rdw, pc4, res;
    logic        we;
  } vec_t;

  localparam int NV = 12;
  vec_t        vt[NV];
  logic [63:0] r;

  initial begin
    vt[0]  = '{1'b1, 2'b00, 3'b000, 5'd5,  32'h1234,     32'h0,        32'h0,   32'h00001234, 1'b1};
    vt[1]  = '{1'b1, 2'b01, 3'b000, 5'd6,  32'h1003,     32'h80FF7F01, 32'h0,   32'hFFFFFF80, 1'b1};
    vt[2]  = '{1'b1, 2'b01, 3'b100, 5'd6,  32'h1001,     32'h80FF7F01, 32'h0,   32'h0000007F, 1'b1};
    vt[3]  = '{1'b1, 2'b01, 3'b001, 5'd6,  32'h1002,     32'h80FF7F01, 32'h0,   32'hFFFF80FF, 1'b1};
    vt[4]  = '{1'b1, 2'b01, 3'b101, 5'd6,  32'h1002,     32'h80FF7F01, 32'h0,   32'h000080FF, 1'b1};
    vt[5]  = '{1'b1, 2'b01, 3'b010, 5'd6,  32'h1001,     32'h80FF7F01, 32'h0,   32'h80FF7F01, 1'b1};
    vt[6]  = '{1'b1, 2'b01, 3'b101, 5'd6,  32'h1003,     32'h80FF7F01, 32'h0,   32'h000080FF, 1'b1};
    vt[7]  = '{1'b1, 2'b01, 3'b011, 5'd6,  32'h1002,     32'h80FF7F01, 32'h0,   32'h80FF7F01, 1'b1};
    vt[8]  = '{1'b1, 2'b10, 3'b000, 5'd1,  32'h0,        32'h0,        32'h104, 32'h00000104, 1'b1};
    vt[9]  = '{1'b1, 2'b10, 3'b000, 5'd0,  32'h0,        32'h0,        32'h104, 32'h00000104, 1'b0};
    vt[10] = '{1'b1, 2'b11, 3'b000, 5'd8,  32'hCAFEF00D, 32'h0,        32'h0,   32'hCAFEF00D, 1'b1};
    vt[11] = '{1'b0, 2'b00, 3'b000, 5'd9,  32'h55,       32'h0,        32'h0,   32'h00000055, 1'b0};

    // Reset with busy inputs: every output must read zero
    rst = 1'b0; StallW = 1'b0; FlushW = 1'b0;
    drive_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'h1, 32'h2, 32'h3);
    ExtValid = 1'b1; ExtRd = 5'd4; ExtData = 32'h77;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ResultW", 64'(ResultW), 64'd0);
    chk("rst_RdW", 64'(RdW), 64'd0);
    chk("rst_RegWriteW", 64'(RegWriteW), 64'd0);
    chk("rst_ExtReady", 64'(ExtReady), 64'd0);
    chk("rst_StallReqW", 64'(StallReqW), 64'd0);
    chk("rst_InstretW", InstretW, 64'd0);
    tick();
    rst = 1'b1;
    ext_idle();

    // Table: vector i is visible at W while vector i+1 is presented
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive_m(1'b1, vt[i].rw, vt[i].src, vt[i].lt, vt[i].rd, vt[i].alu, vt[i].rdw, vt[i].pc4);
      else drive_m(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
      step();
      if (i > 0) begin
        chk("tbl_ResultW", 64'(ResultW), 64'(vt[i-1].res));
        chk("tbl_RdW", 64'(RdW), 64'(vt[i-1].rd));
        chk("tbl_RegWriteW", 64'(RegWriteW), 64'(vt[i-1].we));
        chk("tbl_InstretW", InstretW, 64'(i - 1));
      end
      tick();
    end

    // External write in a free cycle, then ExtRd=0 beside a pipeline write
    ExtValid = 1'b1; ExtRd = 5'd7; ExtData = 32'hDEAD;
    drive_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd10, 32'h77, 32'h0, 32'h0);
    step();
    chk("arb_ExtReady", 64'(ExtReady), 64'd1);
    chk("arb_RdW", 64'(RdW), 64'd7);
    chk("arb_ResultW", 64'(ResultW), 64'hDEAD);
    tick();
    ExtRd = 5'd0; ExtData = 32'h1111;
    drive_m(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("x0_ExtReady", 64'(ExtReady), 64'd1);
    chk("x0_RdW", 64'(RdW), 64'd10);
    chk("x0_ResultW", 64'(ResultW), 64'h77);
    tick();

    // Starvation: four refusals, then the external unit takes the port
    ext_idle();
    drive_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'h300, 32'h0, 32'h0);
    step(); tick();
    for (int k = 1; k <= 4; k++) begin
      ExtValid = 1'b1; ExtRd = 5'd9; ExtData = 32'hBEEF;
      drive_m(1'b1, 1'b1, 2'b00, 3'b000, 5'(3 + k), 32'h300 + 32'(k), 32'h0, 32'h0);
      step();
      chk("starve_wait_ExtReady", 64'(ExtReady), 64'd0);
      chk("starve_wait_StallReqW", 64'(StallReqW), 64'd0);
      tick();
    end
    drive_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd8, 32'h305, 32'h0, 32'h0);
    r = m_ret;
    step();
    chk("starve_StallReqW", 64'(StallReqW), 64'd1);
    chk("starve_ExtReady", 64'(ExtReady), 64'd1);
    chk("starve_RdW", 64'(RdW), 64'd9);
    chk("starve_ResultW", 64'(ResultW), 64'hBEEF);
    tick();
    ext_idle();
    drive_m(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("held_RdW", 64'(RdW), 64'd7);
    chk("held_ResultW", 64'(ResultW), 64'h304);
    chk("held_RegWriteW", 64'(RegWriteW), 64'd1);
    chk("held_InstretW", InstretW, r);
    tick();
    step();
    chk("held_retired", InstretW, r + 64'd1);
    tick();

    // StallW for three cycles, release, then StallW with FlushW
    drive_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd12, 32'hABC, 32'h0, 32'h0);
    step(); tick();
    r = m_ret;
    for (int k = 0; k < 4; k++) begin
      StallW = (k < 3);
      drive_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd13, 32'hDEF, 32'h0, 32'h0);
      step();
      chk("stall_ResultW", 64'(ResultW), 64'hABC);
      chk("stall_RdW", 64'(RdW), 64'd12);
      chk("stall_InstretW", InstretW, r);
      tick();
    end
    StallW = 1'b1; FlushW = 1'b1;
    step();
    chk("preflush_RdW", 64'(RdW), 64'd13);
    chk("preflush_InstretW", InstretW, r + 64'd1);
    tick();
    StallW = 1'b0; FlushW = 1'b0;
    drive_m(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("flush_RegWriteW", 64'(RegWriteW), 64'd0);
    chk("flush_InstretW", InstretW, r + 64'd1);
    tick();

    // Reset in the middle of a pending external request
    ExtValid = 1'b1; ExtRd = 5'd7; ExtData = 32'h99;
    drive_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd4, 32'h44, 32'h0, 32'h0);
    step(); tick();
    step();
    chk("prerst_ExtReady", 64'(ExtReady), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ExtReady", 64'(ExtReady), 64'd0);
    chk("midrst_RegWriteW", 64'(RegWriteW), 64'd0);
    chk("midrst_ResultW", 64'(ResultW), 64'd0);
    chk("midrst_InstretW", InstretW, 64'd0);
    model_reset();
    tick();
    rst = 1'b1;
    drive_m(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    chk("represent_ExtReady", 64'(ExtReady), 64'd1);
    chk("represent_RdW", 64'(RdW), 64'd7);
    tick();
    ext_idle();

    // Random traffic with a well-behaved external unit
    for (int c = 0; c < 600; c++) begin
      if (ExtValid && m_rdy) ExtValid = 1'b0;
      if (!ExtValid) begin
        if ($urandom_range(0, 3) == 0) begin
          ExtValid = 1'b1;
          ExtRd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        end else begin
          ExtRd = 5'($urandom_range(1, 31));
        end
        ExtData = $urandom;
      end
      drive_m($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 8, 2'($urandom),
              3'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              $urandom, $urandom, $urandom);
      StallW = ($urandom_range(0, 9) == 0);
      FlushW = ($urandom_range(0, 14) == 0);
      step();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
